// File: rtl/mmio_fxmul_if.sv
// CPU data-bus slice seen by the fixed-point multiply coprocessor.
// The CPU drives the address, store data and strobe; the block returns read data, hit and busy.
interface mmio_fxmul_if;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic        f_memwrite;
  logic [31:0] rdata;
  logic        sel;
  logic        busy;

  modport master (output memaddr, writedata, f_memwrite, input rdata, sel, busy);
  modport slave  (input memaddr, writedata, f_memwrite, output rdata, sel, busy);
endinterface

// File: rtl/mmio_fxmul.sv
// Memory-mapped signed Q(32-FRAC).FRAC multiplier with saturation.
// Uses a 32-step shift-add datapath, so each operation takes 33 cycles from start to result.
module mmio_fxmul #(
  parameter logic [31:0] BASE = 32'h0000_4000,
  parameter int          FRAC = 28
) (
  input logic        clk,
  input logic        rst,
  mmio_fxmul_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_opa, r_opb, r_result;
  logic [63:0] r_acc;
  logic [31:0] r_mcand, r_mplier;
  logic [4:0]  r_cnt;
  logic        r_sign, r_done, r_ovf;

  logic        w_sel, w_wr, w_wr_opa, w_wr_opb, w_wr_ctrl;
  logic        w_start, w_clr, w_busy;
  logic [31:0] w_abs_a, w_abs_b;
  logic [63:0] w_p, w_q;
  logic        w_fits;
  logic        w_unused_addr;

  assign w_sel     = (bus.memaddr[31:4] == BASE[31:4]);
  assign w_wr      = bus.f_memwrite & w_sel;
  assign w_wr_opa  = w_wr & (bus.memaddr[3:2] == 2'd0);
  assign w_wr_opb  = w_wr & (bus.memaddr[3:2] == 2'd1);
  assign w_wr_ctrl = w_wr & (bus.memaddr[3:2] == 2'd2);
  assign w_start   = w_wr_ctrl & bus.writedata[0] & (r_state == S_IDLE);
  assign w_clr     = w_wr_ctrl & bus.writedata[1];
  assign w_busy    = (r_state != S_IDLE);
  assign w_unused_addr = ^bus.memaddr[1:0];

  // Two's-complement negate gives 2^31 for 32'h8000_0000, which is correct as unsigned.
  assign w_abs_a = r_opa[31] ? (~r_opa + 32'd1) : r_opa;
  assign w_abs_b = r_opb[31] ? (~r_opb + 32'd1) : r_opb;

  assign w_p    = r_sign ? (~r_acc + 64'd1) : r_acc;
  assign w_q    = $signed(w_p) >>> FRAC;
  assign w_fits = (w_q[63:31] == {33{w_q[31]}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nx = S_RUN;
      S_RUN:    if (r_cnt == 5'd31) w_state_nx = S_FINISH;
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_opa) r_opa <= bus.writedata;
      if (w_wr_opb) r_opb <= bus.writedata;
      if (w_clr)    r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mcand  <= w_abs_a;
          r_mplier <= w_abs_b;
          r_sign   <= r_opa[31] ^ r_opb[31];
          r_acc    <= '0;
          r_cnt    <= '0;
          r_done   <= 1'b0;
          r_ovf    <= 1'b0;
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + ({32'd0, r_mcand} << r_cnt);
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        S_FINISH: begin
          if (w_fits) begin
            r_result <= w_q[31:0];
            r_ovf    <= 1'b0;
          end else begin
            r_result <= w_q[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r_ovf    <= 1'b1;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Combinational read path so a load completes in the same cycle as its address.
  always_comb begin
    bus.rdata = '0;
    if (w_sel) begin
      case (bus.memaddr[3:2])
        2'd0: bus.rdata = r_opa;
        2'd1: bus.rdata = r_opb;
        2'd2: bus.rdata = {29'd0, r_ovf, r_done, w_busy};
        default: bus.rdata = r_result;
      endcase
    end
  end

  assign bus.sel  = w_sel;
  assign bus.busy = w_busy;

endmodule
